// File: rtl/led_pattern.sv
// LED pattern sequencer: blink / rotate-left / rotate-right / bounce, advanced by a divided 1 Hz tick.
// Define LED_PATTERN_BOUNCE_EN to build bounce mode; otherwise mode 11 behaves as blink.
module led_pattern #(
  parameter int WIDTH   = 10,
  parameter int STEPDIV = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             gen1hz,
  input  logic [1:0]       mode,
  input  logic             hold,
  output logic [WIDTH-1:0] LED,
  output logic             step
);

  // A divide ratio of 0 is treated as 1.
  localparam int         DIV_EFF  = (STEPDIV < 1) ? 1 : STEPDIV;
  localparam logic [3:0] DIV_LAST = 4'(DIV_EFF - 1);

  localparam logic [1:0] M_BLINK = 2'b00;
  localparam logic [1:0] M_ROTL  = 2'b01;
  localparam logic [1:0] M_ROTR  = 2'b10;

  localparam logic [2:0] ST_UNLOADED = 3'd0;
  localparam logic [2:0] ST_BLINK    = 3'd1;
  localparam logic [2:0] ST_ROTL     = 3'd2;
  localparam logic [2:0] ST_ROTR     = 3'd3;
`ifdef LED_PATTERN_BOUNCE_EN
  localparam logic [1:0] M_BOUNCE    = 2'b11;
  localparam logic [2:0] ST_BOUNCE_L = 3'd4;
  localparam logic [2:0] ST_BOUNCE_R = 3'd5;
`endif

  logic [WIDTH-1:0] led_q, led_d;
  logic             step_q, step_d;
  logic [3:0]       div_q, div_d;
  logic [2:0]       state_q, state_d;

  logic [1:0]       mode_eff;
  logic [1:0]       state_mode;
  logic             tick;
  logic             step_evt;

`ifdef LED_PATTERN_BOUNCE_EN
  assign mode_eff = mode;
`else
  assign mode_eff = (mode == 2'b11) ? M_BLINK : mode;
`endif

  assign tick     = gen1hz & ~hold;
  assign step_evt = tick && (div_q == DIV_LAST);

  // Mode currently held in the state register (mode_r); bounce direction is folded into the state.
  always_comb begin
    state_mode = M_BLINK;
    case (state_q)
      ST_ROTL:     state_mode = M_ROTL;
      ST_ROTR:     state_mode = M_ROTR;
`ifdef LED_PATTERN_BOUNCE_EN
      ST_BOUNCE_L,
      ST_BOUNCE_R: state_mode = M_BOUNCE;
`endif
      default:     state_mode = M_BLINK;
    endcase
  end

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    led_d   = led_q;
    step_d  = 1'b0;
    div_d   = div_q;
    state_d = state_q;

    if (tick) begin
      div_d = step_evt ? 4'd0 : div_q + 4'd1;
    end

    if (step_evt) begin
      step_d = 1'b1;
      if (state_q == ST_UNLOADED || state_mode != mode_eff) begin
        led_d = '0;
        case (mode_eff)
          M_ROTL: begin
            state_d  = ST_ROTL;
            led_d[0] = 1'b1;
          end
          M_ROTR: begin
            state_d        = ST_ROTR;
            led_d[WIDTH-1] = 1'b1;
          end
`ifdef LED_PATTERN_BOUNCE_EN
          M_BOUNCE: begin
            state_d  = ST_BOUNCE_L;
            led_d[0] = 1'b1;
          end
`endif
          default: begin
            state_d = ST_BLINK;
            led_d   = '1;
          end
        endcase
      end else begin
        case (state_q)
          ST_BLINK: led_d = ~led_q;
          ST_ROTL:  led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
          ST_ROTR:  led_d = {led_q[0], led_q[WIDTH-1:1]};
`ifdef LED_PATTERN_BOUNCE_EN
          // End bits force a turn, so each end stays lit for a single step.
          ST_BOUNCE_L,
          ST_BOUNCE_R: begin
            if (led_q[WIDTH-1]) begin
              state_d = ST_BOUNCE_R;
              led_d   = led_q >> 1;
            end else if (led_q[0]) begin
              state_d = ST_BOUNCE_L;
              led_d   = led_q << 1;
            end else if (state_q == ST_BOUNCE_L) begin
              led_d   = led_q << 1;
            end else begin
              led_d   = led_q >> 1;
            end
          end
`endif
          default: led_d = led_q;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      led_q   <= '0;
      step_q  <= 1'b0;
      div_q   <= 4'd0;
      state_q <= ST_UNLOADED;
    end else begin
      led_q   <= led_d;
      step_q  <= step_d;
      div_q   <= div_d;
      state_q <= state_d;
    end
  end

  assign LED  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern.sv
// Scoreboard bench for led_pattern: two instances (STEPDIV 1 and 3) against a position-based reference model.
// Honours LED_PATTERN_BOUNCE_EN the same way as the design.
module tb_led_pattern;
  localparam int W = 10;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         gen1hz = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         hold = 1'b0;
  logic [W-1:0] led0, led1;
  logic         step0, step1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  typedef struct {
    bit loaded;
    int mm;
    int pos;
    int dir;
    bit on;
    int cnt;
  } model_t;
  model_t md[2];

  led_pattern #(.WIDTH(W), .STEPDIV(1)) dut0 (
    .CLK(CLK), .RST(RST), .gen1hz(gen1hz), .mode(mode), .hold(hold), .LED(led0), .step(step0)
  );
  led_pattern #(.WIDTH(W), .STEPDIV(3)) dut1 (
    .CLK(CLK), .RST(RST), .gen1hz(gen1hz), .mode(mode), .hold(hold), .LED(led1), .step(step1)
  );

  always #10 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic reset_model(input int i);
    md[i].loaded = 1'b0;
    md[i].mm     = 0;
    md[i].pos    = 0;
    md[i].dir    = 1;
    md[i].on     = 1'b0;
    md[i].cnt    = 0;
  endtask

  // Reference: a lit position or a blink phase, advanced by arithmetic on each divided tick.
  task automatic model_step(input int i, input bit g, input bit h, input int m,
                            output bit push, output logic [W-1:0] val);
    int em;
    push = 1'b0;
    val  = '0;
    em   = m;
`ifndef LED_PATTERN_BOUNCE_EN
    if (em == 3) em = 0;
`endif
    if (g && !h) begin
      md[i].cnt++;
      if (md[i].cnt >= div_of(i)) begin
        md[i].cnt = 0;
        push = 1'b1;
        if (!md[i].loaded || em != md[i].mm) begin
          md[i].loaded = 1'b1;
          md[i].mm     = em;
          md[i].on     = 1'b1;
          md[i].pos    = (em == 2) ? W - 1 : 0;
          md[i].dir    = 1;
        end else begin
          case (em)
            0: md[i].on  = !md[i].on;
            1: md[i].pos = (md[i].pos + 1) % W;
            2: md[i].pos = (md[i].pos + W - 1) % W;
            default: begin
              if (md[i].pos == W - 1) md[i].dir = -1;
              else if (md[i].pos == 0) md[i].dir = 1;
              md[i].pos = md[i].pos + md[i].dir;
            end
          endcase
        end
        if (md[i].mm == 0) val = md[i].on ? {W{1'b1}} : {W{1'b0}};
        else val = W'(1 << md[i].pos);
      end
    end
  endtask

  task automatic cycle(input bit g, input int m, input bit h);
    bit p;
    logic [W-1:0] v;
    @(negedge CLK);
    gen1hz = g;
    mode   = 2'(m);
    hold   = h;
    model_step(0, g, h, m, p, v);
    if (p) q0.push_back(v);
    model_step(1, g, h, m, p, v);
    if (p) q1.push_back(v);
  endtask

  task automatic pulse(input int m);
    cycle(1'b1, m, 1'b0);
    cycle(1'b0, m, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    gen1hz = 1'b0;
    hold   = 1'b0;
    RST    = 1'b0;
    #1;
    check("rst_led0", 32'(led0), 32'h0);
    check("rst_step0", 32'(step0), 32'h0);
    check("rst_led1", 32'(led1), 32'h0);
    check("rst_step1", 32'(step1), 32'h0);
    reset_model(0);
    reset_model(1);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // Monitor: a step strobe must match the oldest expectation; an expectation without a strobe is a miss.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (step0) begin
        if (q0.size() == 0) check("dut0_unexpected_step", 32'(step0), 32'h0);
        else check("dut0_led", 32'(led0), 32'(q0.pop_front()));
      end else if (q0.size() != 0) begin
        check("dut0_missing_step", 32'(step0), 32'h1);
        void'(q0.pop_front());
      end
      if (step1) begin
        if (q1.size() == 0) check("dut1_unexpected_step", 32'(step1), 32'h0);
        else check("dut1_led", 32'(led1), 32'(q1.pop_front()));
      end else if (q1.size() != 0) begin
        check("dut1_missing_step", 32'(step1), 32'h1);
        void'(q1.pop_front());
      end
    end
  end

  initial begin
    int cur_mode;
    reset_model(0);
    reset_model(1);
    #3;
    check("init_led0", 32'(led0), 32'h0);
    check("init_step0", 32'(step0), 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    cycle(1'b0, 0, 1'b0);

    // Blink
    pulse(0); check("blink_1", 32'(led0), 32'h3FF);
    pulse(0); check("blink_2", 32'(led0), 32'h000);
    pulse(0); check("blink_3", 32'(led0), 32'h3FF);

    // Rotate left / right with wrap
    pulse(1); check("rotl_seed", 32'(led0), 32'h001);
    for (int k = 0; k < 9; k++) pulse(1);
    check("rotl_top", 32'(led0), 32'h200);
    pulse(1); check("rotl_wrap", 32'(led0), 32'h001);
    pulse(2); check("rotr_seed", 32'(led0), 32'h200);
    for (int k = 0; k < 9; k++) pulse(2);
    check("rotr_bottom", 32'(led0), 32'h001);
    pulse(2); check("rotr_wrap", 32'(led0), 32'h200);

    // Bounce (blink when the feature is not built)
    for (int k = 0; k < 10; k++) pulse(3);
`ifdef LED_PATTERN_BOUNCE_EN
    check("bounce_top", 32'(led0), 32'h200);
    pulse(3); check("bounce_turn", 32'(led0), 32'h100);
    for (int k = 0; k < 9; k++) pulse(3);
    check("bounce_end", 32'(led0), 32'h002);
`else
    check("mode3_blink_a", 32'(led0), 32'h000);
    for (int k = 0; k < 10; k++) pulse(3);
    check("mode3_blink_b", 32'(led0), 32'h000);
`endif

    // Hold freezes pattern and suppresses step
    pulse(1); pulse(1); pulse(1);
    check("hold_pre", 32'(led0), 32'h004);
    cycle(1'b1, 1, 1'b1); cycle(1'b0, 1, 1'b1);
    cycle(1'b1, 1, 1'b1); cycle(1'b0, 1, 1'b1);
    check("hold_led", 32'(led0), 32'h004);
    check("hold_step", 32'(step0), 32'h0);
    pulse(1); check("hold_release", 32'(led0), 32'h008);

    // Mode change between steps takes effect only on the next step
    cycle(1'b0, 2, 1'b0); cycle(1'b0, 2, 1'b0); cycle(1'b0, 2, 1'b0);
    check("mode_chg_wait", 32'(led0), 32'h008);
    pulse(2); check("mode_chg_load", 32'(led0), 32'h200);

    // Consecutive high gen1hz cycles each count
    cycle(1'b1, 2, 1'b0); cycle(1'b1, 2, 1'b0); cycle(1'b1, 2, 1'b0);
    cycle(1'b0, 2, 1'b0);
    check("consecutive", 32'(led0), 32'h040);

    // STEPDIV=3 and reset mid-count
    do_reset();
    pulse(1); pulse(1);
    check("div3_p2", 32'(led1), 32'h000);
    pulse(1); check("div3_p3", 32'(led1), 32'h001);
    pulse(1); pulse(1);
    check("div3_p5", 32'(led1), 32'h001);
    pulse(1); check("div3_p6", 32'(led1), 32'h002);
    pulse(1);
    do_reset();
    pulse(1); pulse(1);
    check("div3_rst_p2", 32'(led1), 32'h000);
    pulse(1); check("div3_rst_p3", 32'(led1), 32'h001);

    // Randomized run against the model
    cur_mode = 1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 19) == 0) cur_mode = int'($urandom_range(0, 3));
        cycle($urandom_range(0, 2) == 0, cur_mode, $urandom_range(0, 7) == 0);
      end
    end
    cycle(1'b0, cur_mode, 1'b0);
    cycle(1'b0, cur_mode, 1'b0);
    check("q0_drained", 32'(q0.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern.md
LED_PATTERN -- requirements
Module: led_pattern

Interface
REQ-001 Parameter WIDTH, default 10, number of LED outputs; legal range 2..16.
REQ-002 Parameter STEPDIV, default 1, gen1hz ticks per pattern step; legal range 1..15, value 0 SHALL behave as 1.
REQ-003 CLK  input  1  system clock, 50 MHz, rising-edge active.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 gen1hz  input  1  one-cycle-high tick from the upstream 1 s counter, synchronous to CLK.
REQ-006 mode  input  2  pattern select: 00 blink, 01 rotate-left, 10 rotate-right, 11 bounce.
REQ-007 hold  input  1  high freezes the pattern and the tick divider.
REQ-008 LED  output  WIDTH  registered LED drive, 1 = lit.
REQ-009 step  output  1  registered one-cycle strobe, high in the same cycle LED takes a new value.

Function
REQ-010 A tick is gen1hz==1 and hold==0 at a CLK rising edge; every such cycle counts, including consecutive high cycles.
REQ-011 The divider counts ticks 0..STEPDIV-1; the tick that finds the divider at STEPDIV-1 clears it and produces a step event. Any other tick increments it.
REQ-012 LED and step SHALL update on the rising edge following the step-event cycle, giving 1-cycle latency from gen1hz to LED.
REQ-013 On a step event, mode SHALL be sampled. If mode differs from the registered mode_r, or the loaded flag is 0, the block SHALL set mode_r to mode and loaded to 1, set LED to the mode's seed, and, for bounce, set dir to left.
REQ-014 Seeds: blink is all ones; rotate-left is bit0 only; rotate-right is bit WIDTH-1 only; bounce is bit0 only.
REQ-015 Otherwise, on a step event the block SHALL advance the pattern as follows. Blink: LED is set to ~LED. Rotate-left: LED is set to {LED[WIDTH-2:0], LED[WIDTH-1]}. Rotate-right: LED is set to {LED[0], LED[WIDTH-1:1]}.
REQ-016 Bounce moves the single lit bit one position in dir. When bit WIDTH-1 is lit, dir SHALL become right and the next step lights bit WIDTH-2. When bit0 is lit, dir SHALL become left. The end bits are therefore lit for one step only.
REQ-017 The internal state is {loaded, mode_r, dir}, with states UNLOADED, BLINK, ROTL, ROTR, BOUNCE_L, BOUNCE_R. The only transitions are on step events, as given in REQ-013 to REQ-016.
REQ-018 A change on mode between step events SHALL have no effect until the next step event.
REQ-019 While hold==1, LED, divider, state and dir SHALL hold, and step SHALL be 0.
REQ-020 step SHALL be 0 in every cycle except the cycle LED updates, including a mode reload.

Reset
REQ-021 While RST==0, asynchronously: LED=0, step=0, divider=0, loaded=0, mode_r=00, dir=left.
REQ-022 A reset asserted at any point, including in the middle of a divider count, SHALL discard all progress. The first step event after release SHALL load a seed per REQ-013.

Configuration
REQ-023 Macro LED_PATTERN_BOUNCE_EN.
- Defined: mode 11 selects bounce as specified above.
- Undefined: mode 11 SHALL be treated as 00 (blink) everywhere, including the REQ-013 comparison. No dir register is built.

Verification
REQ-024 Reset, then a gen1hz pulse with mode=00 and WIDTH=10 -> LED=0x3FF and step=1 for 1 cycle. The second pulse -> LED=0x000. The third pulse -> LED=0x3FF.
REQ-025 mode=01, 11 pulses -> LED=0x001, 0x002, ... 0x200, then 0x001 (wrap). mode=10 mirrors this: 0x200 down to 0x001, then 0x200.
REQ-026 mode=11, 20 pulses -> LED=0x001 .. 0x200 then 0x100 .. 0x001, then 0x002. With the macro undefined -> the blink sequence of REQ-024.
REQ-027 STEPDIV=3, mode=01, 6 pulses -> LED changes only on pulses 3 and 6. Asserting RST low after pulse 4, then releasing -> LED=0, and the next 3 pulses are needed for the seed 0x001.
REQ-028 hold=1 during 2 pulses in mode 01 at LED=0x004 -> LED stays 0x004 and step=0. After hold drops, the next pulse -> 0x008.
REQ-029 mode changed 01->10 mid-interval -> LED unchanged until the next pulse, which loads 0x200.
